// File: rtl/pkg_dtypes.sv
// Shared exec-unit datatypes: xbuf address/data words plus the operand-fetch
// instruction record and FSM state encoding.
package pkg_dtypes;

  localparam int unsigned EXEC_UNIT_ADDR_W = 8;
  localparam int unsigned EXEC_UNIT_DATA_W = 16;

  typedef logic [EXEC_UNIT_ADDR_W-1:0] type_exec_unit_addr;
  typedef logic [EXEC_UNIT_DATA_W-1:0] type_exec_unit_data;

  typedef struct packed {
    type_exec_unit_addr opa_addr;
    type_exec_unit_addr opb_addr;
    logic               opa_is_imm;
    logic               opb_is_imm;
    type_exec_unit_data imm;
    type_exec_unit_addr dest_addr;
  } type_eu_opfetch_ins;

  typedef enum logic [1:0] {
    OPF_IDLE,
    OPF_FETCH_A,
    OPF_FETCH_B,
    OPF_ISSUE
  } type_eu_opfetch_state;

endpackage

// File: rtl/eu_opfetch_stall_ctr.sv
// Saturating cycle counter with synchronous clear; counts unanswered xbuf request cycles.
module eu_opfetch_stall_ctr #(
  parameter int unsigned STALL_LIMIT = 64
) (
  input  logic                             clk,
  input  logic                             reset_n,
  input  logic                             clr,
  input  logic                             inc,
  output logic [$clog2(STALL_LIMIT+1)-1:0] count
);

  localparam int unsigned CNT_W = $clog2(STALL_LIMIT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STALL_LIMIT);

  always_ff @(posedge clk) begin
    if (!reset_n || clr) begin
      count <= '0;
    end else if (inc && (count != CNT_MAX)) begin
      count <= count + CNT_W'(1);
    end
  end

endmodule

// File: rtl/eu_operand_fetch.sv
// Operand-fetch initiator: pulls up to two operands from the xbuf and hands them to the ALU.
// Define EU_OPFETCH_TIMEOUT_EN to build the request stall counter behind stall_err_o.
module eu_operand_fetch
  import pkg_dtypes::*;
#(
  parameter int unsigned STALL_LIMIT = 64
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               flush_i,
  input  logic               ins_valid_i,
  output logic               ins_ready_o,
  input  type_eu_opfetch_ins ins_i,
  output type_exec_unit_addr req_addr_o,
  output logic               req_valid_o,
  input  type_exec_unit_data resp_data_i,
  input  logic               resp_success_i,
  output logic               alu_valid_o,
  input  logic               alu_ready_i,
  output type_exec_unit_data alu_opa_o,
  output type_exec_unit_data alu_opb_o,
  output type_exec_unit_addr alu_dest_o,
  output logic               stall_err_o
);

  if (STALL_LIMIT == 0) begin : g_bad_stall_limit
    $error("STALL_LIMIT must be at least 1");
  end

  type_eu_opfetch_state state;
  type_exec_unit_data   opa_q;
  type_exec_unit_data   opb_q;
  type_exec_unit_addr   opb_addr_q;
  logic                 opb_imm_q;
  type_exec_unit_addr   dest_q;
  logic                 req_valid_q;
  type_exec_unit_addr   req_addr_q;
  logic                 alu_valid_q;
  logic                 accept;

  // Flush wins over a new instruction, so ready is withheld rather than dropping an accepted one.
  assign ins_ready_o = reset_n && !flush_i &&
                       ((state == OPF_IDLE) || ((state == OPF_ISSUE) && alu_ready_i));
  assign accept      = ins_valid_i && ins_ready_o;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state       <= OPF_IDLE;
      opa_q       <= '0;
      opb_q       <= '0;
      opb_addr_q  <= '0;
      opb_imm_q   <= 1'b0;
      dest_q      <= '0;
      req_valid_q <= 1'b0;
      req_addr_q  <= '0;
      alu_valid_q <= 1'b0;
    end else if (flush_i) begin
      state       <= OPF_IDLE;
      req_valid_q <= 1'b0;
      req_addr_q  <= '0;
      alu_valid_q <= 1'b0;
    end else begin
      case (state)
        OPF_IDLE, OPF_ISSUE: begin
          if (accept) begin
            opb_addr_q <= ins_i.opb_addr;
            opb_imm_q  <= ins_i.opb_is_imm;
            dest_q     <= ins_i.dest_addr;
            if (ins_i.opa_is_imm) opa_q <= ins_i.imm;
            if (ins_i.opb_is_imm) opb_q <= ins_i.imm;
            if (!ins_i.opa_is_imm) begin
              state       <= OPF_FETCH_A;
              req_valid_q <= 1'b1;
              req_addr_q  <= ins_i.opa_addr;
              alu_valid_q <= 1'b0;
            end else if (!ins_i.opb_is_imm) begin
              state       <= OPF_FETCH_B;
              req_valid_q <= 1'b1;
              req_addr_q  <= ins_i.opb_addr;
              alu_valid_q <= 1'b0;
            end else begin
              state       <= OPF_ISSUE;
              req_valid_q <= 1'b0;
              req_addr_q  <= '0;
              alu_valid_q <= 1'b1;
            end
          end else if ((state == OPF_ISSUE) && alu_ready_i) begin
            state       <= OPF_IDLE;
            alu_valid_q <= 1'b0;
          end
        end
        OPF_FETCH_A: begin
          if (resp_success_i) begin
            opa_q <= resp_data_i;
            if (opb_imm_q) begin
              state       <= OPF_ISSUE;
              req_valid_q <= 1'b0;
              req_addr_q  <= '0;
              alu_valid_q <= 1'b1;
            end else begin
              state      <= OPF_FETCH_B;
              req_addr_q <= opb_addr_q;
            end
          end
        end
        OPF_FETCH_B: begin
          if (resp_success_i) begin
            opb_q       <= resp_data_i;
            state       <= OPF_ISSUE;
            req_valid_q <= 1'b0;
            req_addr_q  <= '0;
            alu_valid_q <= 1'b1;
          end
        end
        default: begin
          state       <= OPF_IDLE;
          req_valid_q <= 1'b0;
          alu_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign req_valid_o = req_valid_q;
  assign req_addr_o  = req_addr_q;
  assign alu_valid_o = alu_valid_q;
  assign alu_opa_o   = opa_q;
  assign alu_opb_o   = opb_q;
  assign alu_dest_o  = dest_q;

`ifdef EU_OPFETCH_TIMEOUT_EN
  localparam int unsigned STALL_W = $clog2(STALL_LIMIT + 1);

  logic [STALL_W-1:0] stall_count;
  logic               fetching;
  logic               stall_inc;
  logic               stall_clr;
  logic               stall_err_q;

  // Any cycle that is not an unanswered fetch (hit, other state, flush) restarts the count.
  assign fetching  = (state == OPF_FETCH_A) || (state == OPF_FETCH_B);
  assign stall_inc = fetching && !resp_success_i;
  assign stall_clr = flush_i || !stall_inc;

  eu_opfetch_stall_ctr #(
    .STALL_LIMIT(STALL_LIMIT)
  ) u_stall_ctr (
    .clk    (clk),
    .reset_n(reset_n),
    .clr    (stall_clr),
    .inc    (stall_inc),
    .count  (stall_count)
  );

  always_ff @(posedge clk) begin
    if (!reset_n || flush_i) begin
      stall_err_q <= 1'b0;
    end else if (stall_inc && (stall_count >= STALL_W'(STALL_LIMIT - 1))) begin
      stall_err_q <= 1'b1;
    end
  end

  assign stall_err_o = stall_err_q;
`else
  assign stall_err_o = 1'b0;
`endif

endmodule

// File: tb/tb_eu_operand_fetch.sv
// Self-checking bench for eu_operand_fetch: xbuf memory model plus an ALU-side scoreboard.
module tb_eu_operand_fetch;
  import pkg_dtypes::*;

  typedef struct packed {
    type_exec_unit_data opa;
    type_exec_unit_data opb;
    type_exec_unit_addr dest;
  } exp_t;

  logic               clk = 1'b0;
  logic               reset_n = 1'b0;
  logic               flush_i = 1'b0;
  logic               ins_valid_i = 1'b0;
  logic               ins_ready_o;
  type_eu_opfetch_ins ins_i = '0;
  type_exec_unit_addr req_addr_o;
  logic               req_valid_o;
  type_exec_unit_data resp_data_i;
  logic               resp_success_i = 1'b0;
  logic               alu_valid_o;
  logic               alu_ready_i = 1'b0;
  type_exec_unit_data alu_opa_o;
  type_exec_unit_data alu_opb_o;
  type_exec_unit_addr alu_dest_o;
  logic               stall_err_o;

  type_exec_unit_data mem [256];
  exp_t               sb [$];
  exp_t               sb_head;
  int unsigned        n_checks = 0;
  int unsigned        n_pass = 0;

  eu_operand_fetch #(
    .STALL_LIMIT(8)
  ) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .flush_i       (flush_i),
    .ins_valid_i   (ins_valid_i),
    .ins_ready_o   (ins_ready_o),
    .ins_i         (ins_i),
    .req_addr_o    (req_addr_o),
    .req_valid_o   (req_valid_o),
    .resp_data_i   (resp_data_i),
    .resp_success_i(resp_success_i),
    .alu_valid_o   (alu_valid_o),
    .alu_ready_i   (alu_ready_i),
    .alu_opa_o     (alu_opa_o),
    .alu_opb_o     (alu_opb_o),
    .alu_dest_o    (alu_dest_o),
    .stall_err_o   (stall_err_o)
  );

  always #5 clk = ~clk;

  assign resp_data_i = mem[req_addr_o];

  // ALU side: every completed handshake must match the oldest expected instruction.
  always @(negedge clk) begin
    if (reset_n && alu_valid_o && alu_ready_i) begin
      n_checks++;
      if (sb.size() == 0) begin
        $display("FAIL alu_handshake: unexpected issue opa=%h opb=%h dest=%h, required no issue",
                 alu_opa_o, alu_opb_o, alu_dest_o);
      end else begin
        sb_head = sb.pop_front();
        if ({alu_opa_o, alu_opb_o, alu_dest_o} !== sb_head) begin
          $display("FAIL alu_operands: opa=%h opb=%h dest=%h, required opa=%h opb=%h dest=%h",
                   alu_opa_o, alu_opb_o, alu_dest_o, sb_head.opa, sb_head.opb, sb_head.dest);
        end else begin
          n_pass++;
        end
      end
    end
  end

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  function automatic type_eu_opfetch_ins mk(input type_exec_unit_addr a, input type_exec_unit_addr b,
                                            input logic ai, input logic bi,
                                            input type_exec_unit_data imm, input type_exec_unit_addr d);
    type_eu_opfetch_ins x;
    x.opa_addr   = a;
    x.opb_addr   = b;
    x.opa_is_imm = ai;
    x.opb_is_imm = bi;
    x.imm        = imm;
    x.dest_addr  = d;
    return x;
  endfunction

  function automatic exp_t model(input type_eu_opfetch_ins x);
    exp_t e;
    e.opa  = x.opa_is_imm ? x.imm : mem[x.opa_addr];
    e.opb  = x.opb_is_imm ? x.imm : mem[x.opb_addr];
    e.dest = x.dest_addr;
    return e;
  endfunction

  task automatic offer(input type_eu_opfetch_ins x);
    ins_i       = x;
    ins_valid_i = 1'b1;
    sb.push_back(model(x));
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    next_cycle();
    next_cycle();
    mid();
    n_checks++;
    if ({ins_ready_o, req_valid_o, alu_valid_o, stall_err_o} !== 4'b0000) begin
      $display("FAIL reset_ctrl: ready/req/alu/stall=%b, required 0000",
               {ins_ready_o, req_valid_o, alu_valid_o, stall_err_o});
    end else n_pass++;
    n_checks++;
    if ({req_addr_o, alu_opa_o, alu_opb_o, alu_dest_o} !== '0) begin
      $display("FAIL reset_data: addr=%h opa=%h opb=%h dest=%h, required all 0",
               req_addr_o, alu_opa_o, alu_opb_o, alu_dest_o);
    end else n_pass++;
    next_cycle();
    reset_n = 1'b1;
    mid();
    n_checks++;
    if (ins_ready_o !== 1'b1 || req_valid_o !== 1'b0) begin
      $display("FAIL reset_release: ins_ready=%b req_valid=%b, required 1 0", ins_ready_o, req_valid_o);
    end else n_pass++;
    next_cycle();
  endtask

  task automatic test_latency();
    type_eu_opfetch_ins tbl [5];
    tbl[0] = mk(8'h03, 8'h05, 1'b0, 1'b0, 16'h0000, 8'h09);
    tbl[1] = mk(8'h40, 8'h41, 1'b0, 1'b1, 16'h007F, 8'h44);
    tbl[2] = mk(8'h42, 8'h43, 1'b1, 1'b0, 16'h0123, 8'h45);
    tbl[3] = mk(8'h00, 8'h00, 1'b1, 1'b1, 16'h55AA, 8'h66);
    tbl[4] = mk(8'h07, 8'h07, 1'b0, 1'b0, 16'h0000, 8'h77);
    resp_success_i = 1'b1;
    alu_ready_i    = 1'b1;
    foreach (tbl[i]) begin
      int unsigned        n;
      logic               e_rv;
      logic               e_av;
      type_exec_unit_addr e_ra;
      n = 0;
      if (!tbl[i].opa_is_imm) n++;
      if (!tbl[i].opb_is_imm) n++;
      offer(tbl[i]);
      mid();
      n_checks++;
      if (ins_ready_o !== 1'b1) begin
        $display("FAIL latency_accept[%0d]: ins_ready=%b, required 1", i, ins_ready_o);
      end else n_pass++;
      next_cycle();
      ins_valid_i = 1'b0;
      for (int unsigned c = 1; c <= n + 2; c++) begin
        e_rv = (c <= n);
        e_av = (c == n + 1);
        e_ra = (c == 1 && !tbl[i].opa_is_imm) ? tbl[i].opa_addr : tbl[i].opb_addr;
        mid();
        n_checks++;
        if (req_valid_o !== e_rv || (e_rv && req_addr_o !== e_ra) || alu_valid_o !== e_av) begin
          $display("FAIL latency[%0d] cycle %0d: req_valid=%b addr=%h alu_valid=%b, required %b %h %b",
                   i, c, req_valid_o, req_addr_o, alu_valid_o, e_rv, e_ra, e_av);
        end else n_pass++;
        next_cycle();
      end
    end
  endtask

  task automatic test_miss_a();
    logic               e_av;
    logic               e_rv;
    type_exec_unit_addr e_ra;
    resp_success_i = 1'b0;
    alu_ready_i    = 1'b1;
    offer(mk(8'h20, 8'h21, 1'b0, 1'b0, 16'h0000, 8'h33));
    next_cycle();
    ins_valid_i = 1'b0;
    for (int unsigned c = 1; c <= 8; c++) begin
      resp_success_i = (c >= 5);
      e_rv = (c <= 6);
      e_ra = (c <= 5) ? 8'h20 : 8'h21;
      e_av = (c == 7);
      mid();
      n_checks++;
      if (req_valid_o !== e_rv || (e_rv && req_addr_o !== e_ra) || alu_valid_o !== e_av) begin
        $display("FAIL miss_a cycle %0d: req_valid=%b addr=%h alu_valid=%b, required %b %h %b",
                 c, req_valid_o, req_addr_o, alu_valid_o, e_rv, e_ra, e_av);
      end else n_pass++;
      next_cycle();
    end
    resp_success_i = 1'b1;
  endtask

  task automatic test_back_to_back();
    resp_success_i = 1'b1;
    alu_ready_i    = 1'b0;
    offer(mk(8'h50, 8'h51, 1'b0, 1'b0, 16'h0000, 8'h5C));
    next_cycle();
    ins_valid_i = 1'b0;
    next_cycle();
    next_cycle();
    for (int unsigned c = 3; c <= 5; c++) begin
      mid();
      n_checks++;
      if (alu_valid_o !== 1'b1 || ins_ready_o !== 1'b0 ||
          {alu_opa_o, alu_opb_o, alu_dest_o} !== {mem[8'h50], mem[8'h51], 8'h5C}) begin
        $display("FAIL hold cycle %0d: alu_valid=%b ins_ready=%b opa=%h opb=%h dest=%h, required 1 0 %h %h 5c",
                 c, alu_valid_o, ins_ready_o, alu_opa_o, alu_opb_o, alu_dest_o, mem[8'h50], mem[8'h51]);
      end else n_pass++;
      next_cycle();
    end
    alu_ready_i = 1'b1;
    offer(mk(8'h60, 8'h61, 1'b0, 1'b0, 16'h0000, 8'h6D));
    mid();
    n_checks++;
    if (ins_ready_o !== 1'b1 || alu_valid_o !== 1'b1) begin
      $display("FAIL handoff: ins_ready=%b alu_valid=%b, required 1 1", ins_ready_o, alu_valid_o);
    end else n_pass++;
    next_cycle();
    ins_valid_i = 1'b0;
    mid();
    n_checks++;
    if (req_valid_o !== 1'b1 || req_addr_o !== 8'h60 || alu_valid_o !== 1'b0) begin
      $display("FAIL no_bubble: req_valid=%b addr=%h alu_valid=%b, required 1 60 0",
               req_valid_o, req_addr_o, alu_valid_o);
    end else n_pass++;
    for (int unsigned c = 0; c < 4; c++) next_cycle();
  endtask

  task automatic test_flush();
    resp_success_i = 1'b1;
    alu_ready_i    = 1'b1;
    ins_i          = mk(8'h70, 8'h71, 1'b0, 1'b0, 16'h0000, 8'h7A);
    ins_valid_i    = 1'b1;
    next_cycle();
    ins_valid_i = 1'b0;
    next_cycle();
    flush_i = 1'b1;
    mid();
    n_checks++;
    if (req_valid_o !== 1'b1 || req_addr_o !== 8'h71) begin
      $display("FAIL flush_setup: req_valid=%b addr=%h, required 1 71", req_valid_o, req_addr_o);
    end else n_pass++;
    next_cycle();
    flush_i = 1'b0;
    mid();
    n_checks++;
    if (alu_valid_o !== 1'b0 || req_valid_o !== 1'b0 || ins_ready_o !== 1'b1) begin
      $display("FAIL flush_fetch_b: alu_valid=%b req_valid=%b ins_ready=%b, required 0 0 1",
               alu_valid_o, req_valid_o, ins_ready_o);
    end else n_pass++;
    next_cycle();
    flush_i     = 1'b1;
    ins_i       = mk(8'h72, 8'h73, 1'b0, 1'b0, 16'h0000, 8'h7B);
    ins_valid_i = 1'b1;
    next_cycle();
    flush_i     = 1'b0;
    ins_valid_i = 1'b0;
    for (int unsigned c = 0; c < 2; c++) begin
      mid();
      n_checks++;
      if (req_valid_o !== 1'b0 || alu_valid_o !== 1'b0) begin
        $display("FAIL flush_over_accept %0d: req_valid=%b alu_valid=%b, required 0 0",
                 c, req_valid_o, alu_valid_o);
      end else n_pass++;
      next_cycle();
    end
  endtask

  task automatic test_reset_mid_fetch();
    resp_success_i = 1'b0;
    ins_i          = mk(8'h80, 8'h81, 1'b0, 1'b0, 16'h0000, 8'h8F);
    ins_valid_i    = 1'b1;
    next_cycle();
    ins_valid_i = 1'b0;
    next_cycle();
    reset_n = 1'b0;
    next_cycle();
    reset_n = 1'b1;
    mid();
    n_checks++;
    if (req_valid_o !== 1'b0 || req_addr_o !== 8'h00 || alu_valid_o !== 1'b0 || ins_ready_o !== 1'b1) begin
      $display("FAIL reset_mid_fetch: req_valid=%b addr=%h alu_valid=%b ins_ready=%b, required 0 00 0 1",
               req_valid_o, req_addr_o, alu_valid_o, ins_ready_o);
    end else n_pass++;
    next_cycle();
    resp_success_i = 1'b1;
  endtask

  task automatic test_stall();
    logic e_err;
    resp_success_i = 1'b0;
    alu_ready_i    = 1'b1;
    ins_i          = mk(8'h90, 8'h91, 1'b0, 1'b0, 16'h0000, 8'h9F);
    ins_valid_i    = 1'b1;
    next_cycle();
    ins_valid_i = 1'b0;
    for (int unsigned c = 1; c <= 15; c++) begin
`ifdef EU_OPFETCH_TIMEOUT_EN
      e_err = (c >= 9);
`else
      e_err = 1'b0;
`endif
      mid();
      n_checks++;
      if (stall_err_o !== e_err || req_valid_o !== 1'b1 || req_addr_o !== 8'h90) begin
        $display("FAIL stall cycle %0d: stall_err=%b req_valid=%b addr=%h, required %b 1 90",
                 c, stall_err_o, req_valid_o, req_addr_o, e_err);
      end else n_pass++;
      next_cycle();
    end
    flush_i = 1'b1;
    next_cycle();
    flush_i = 1'b0;
    mid();
    n_checks++;
    if (stall_err_o !== 1'b0 || req_valid_o !== 1'b0) begin
      $display("FAIL stall_flush: stall_err=%b req_valid=%b, required 0 0", stall_err_o, req_valid_o);
    end else n_pass++;
    next_cycle();
    resp_success_i = 1'b1;
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 16'(i * 16'h0101) ^ 16'h3C00;
    mem[8'h03] = 16'h0011;
    mem[8'h05] = 16'h0022;
    mem[8'h07] = 16'hBEEF;
    mem[8'h40] = 16'h1234;
    mem[8'h43] = 16'h4343;
    mem[8'h20] = 16'hA5A5;
    mem[8'h21] = 16'h5A5A;

    test_reset();
    test_latency();
    test_miss_a();
    test_back_to_back();
    test_flush();
    test_reset_mid_fetch();
    test_stall();

    n_checks++;
    if (sb.size() != 0) begin
      $display("FAIL scoreboard_drain: %0d issues outstanding, required 0", sb.size());
    end else n_pass++;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog expired");
  end

endmodule
